ld_st_mem_ctrl: RTL and testbench
=================================

LD_ST_MEM_CTRL -- requirements
Module: ld_st_mem_ctrl

Interface
REQ-001 SHALL have parameters: ROB_TAG_W, default 5, ROB tag width; STB_DEPTH, default 4, store-buffer entries (power of 2, >=2).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  discard the in-flight load result
- head_valid  in  1  queue head present
- head_is_st  in  1  1 = store, 0 = load
- head_addr  in  32  byte address
- head_addr_vld  in  1  address resolved
- head_wdata  in  32  store data
- head_wdata_vld  in  1  store data resolved
- head_rob  in  ROB_TAG_W  ROB tag
- head_funct3  in  3  RV32 funct3
- head_pop  out  1  dequeue pulse
- res_valid / res_st / res_exc  out  1 each  result-bus valid / store flag / misalign-or-illegal flag
- res_rob  out  ROB_TAG_W  result tag
- res_value  out  32  load value
- pmem_read / pmem_write  out  1 each  memory requests
- pmem_address  out  32  word-aligned address
- pmem_wdata  out  32  lane-shifted write data
- pmem_byte_enable  out  4  write lanes
- pmem_rdata  in  32  read data
- pmem_resp  in  1  request complete

Function
REQ-004 SHALL decode funct3 as follows: loads lb=000, lh=001, lw=010, lbu=100, lhu=101; stores sb=000, sh=001, sw=010; any other value is illegal.
REQ-005 SHALL treat lh/lhu/sh at offset[0]=1 and lw/sw at offset[1:0]!=0 as misaligned, with no memory access.
REQ-006 SHALL accept a store when head_valid, head_is_st, addr_vld, wdata_vld and the buffer is not full: pulse head_pop that cycle, then res_valid=1, res_st=1, res_rob one cycle later.
REQ-007 SHALL handle an illegal or misaligned store by popping it with res_exc=1 on the next cycle; the store is not buffered.
REQ-008 SHALL store each buffer entry as a word address, byte enable, and lane-shifted data: sb uses 0001<<off and data<<8*off; sh uses 0011<<off and data<<8*off; sw uses 1111.
REQ-009 SHALL implement an FSM with states IDLE, LD_WAIT and ST_WAIT, leaving IDLE for at most one request per cycle.
REQ-010 SHALL issue from IDLE in this priority order: drain if the buffer is full, else a load if eligible, else drain if the buffer is not empty.
REQ-011 SHALL consider a load eligible only when head_valid, !head_is_st, addr_vld, and no buffer entry matches its word address; a matching load stalls until that entry drains.
REQ-012 SHALL register pmem_read/write, pmem_address, pmem_wdata and pmem_byte_enable, and hold them stable until the cycle pmem_resp=1; they drop on the following cycle.
REQ-013 SHALL, on a load pmem_resp, pulse head_pop and register the result (res_valid=1, res_st=0) for the next cycle, then return to IDLE.
REQ-014 SHALL form load values as: lb/lbu take byte off, sign- or zero-extended; lh/lhu take the half at off, sign- or zero-extended; lw takes the full word.
REQ-015 SHALL handle an illegal or misaligned load by popping it with res_exc=1 and res_value=0, with no memory access.
REQ-016 SHALL, on a store pmem_resp, pop the buffer head and return to IDLE; drains produce no result-bus activity.
REQ-017 SHALL, when flush=1 in LD_WAIT, still wait for pmem_resp, then suppress head_pop and res_valid; flush never clears the buffer.
REQ-018 SHALL, on a same-cycle store accept and drain pop, keep the occupancy count unchanged; the pointers SHALL wrap modulo STB_DEPTH.
REQ-019 SHALL register all result outputs, and SHALL drive res_value=0 whenever res_valid=0.

Reset
REQ-020 SHALL, when rst=0, asynchronously force state IDLE, empty the buffer (pointers and count 0), and set every output to 0, including pmem_byte_enable=0000.
REQ-021 SHALL, if reset is asserted mid-transaction, abandon the transaction with no pop and no result after release.

Structure
REQ-022 SHALL place the funct3 localparams and the result-bus typedef (valid, st, exc, rob, value) in package Ld_St_structs.
REQ-023 SHALL implement the buffer as sub-module ld_st_store_buffer: a FIFO with a parallel word-address match output.

Verification
REQ-024 SHALL cover: sb at 0x103 with data 0xAB, then drain -> byte enable 1000, wdata 0xAB000000, address 0x100.
REQ-025 SHALL cover: lb from 0x201 with rdata 0x0000F000 -> value 0xFFFFFFF0; lbu from 0x201 -> 0x000000F0.
REQ-026 SHALL cover: sw 0x300, then lw 0x300 -> the load issues only after the store's pmem_resp and returns the stored value.
REQ-027 SHALL cover: 4 stores with pmem_resp stuck at 0 -> the 5th store is not popped until the first drain completes.
REQ-028 SHALL cover: lw at 0x302 -> res_exc=1, and no pmem_read in any cycle.
REQ-029 SHALL cover: flush during LD_WAIT -> no res_valid and no head_pop; reset in ST_WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/ld_st_mem_ctrl_pkg.sv
// Shared decode constants, result-bus record and controller state encoding
// for the load/store memory controller.
package Ld_St_structs;

  // RV32 funct3 encodings for the supported memory operations
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Widest ROB tag the result record can carry; narrower tags are zero-padded
  localparam int ROB_TAG_MAX = 16;

  typedef struct packed {
    logic                   valid;
    logic                   st;
    logic                   exc;
    logic [ROB_TAG_MAX-1:0] rob;
    logic [31:0]            value;
  } res_bus_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  // Halfwords need an even offset, words a zero offset; bytes never misalign
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/ld_st_store_buffer.sv
// Store buffer: FIFO of pending word writes with a parallel word-address
// match so younger loads can detect a hazard against any queued store.
module ld_st_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [29:0] push_addr,
  input  logic [3:0]  push_be,
  input  logic [31:0] push_data,
  input  logic        pop,
  input  logic [29:0] match_addr,
  output logic [29:0] head_addr,
  output logic [3:0]  head_be,
  output logic [31:0] head_data,
  output logic        full,
  output logic        empty,
  output logic        match
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [29:0]      addr_mem [DEPTH];
  logic [3:0]       be_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] hit;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  // FIFO storage and pointers; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        be_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
      valid_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        addr_mem[wr_ptr_reg]  <= push_addr;
        be_mem[wr_ptr_reg]    <= push_be;
        data_mem[wr_ptr_reg]  <= push_data;
        valid_reg[wr_ptr_reg] <= 1'b1;
        wr_ptr_reg            <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        valid_reg[rd_ptr_reg] <= 1'b0;
        rd_ptr_reg            <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Every occupied entry compares its word address against the probing load
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign hit[gi] = valid_reg[gi] && (addr_mem[gi] == match_addr);
    end
  endgenerate

  assign match     = |hit;
  assign full      = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign head_addr = addr_mem[rd_ptr_reg];
  assign head_be   = be_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

endmodule

// File: rtl/ld_st_mem_ctrl.sv
// Load/store memory controller: buffers stores, drains them to memory,
// issues loads once no buffered store overlaps, and reports results.
module ld_st_mem_ctrl
  import Ld_St_structs::*;
#(
  parameter int ROB_TAG_W = 5,
  parameter int STB_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 head_valid,
  input  logic                 head_is_st,
  input  logic [31:0]          head_addr,
  input  logic                 head_addr_vld,
  input  logic [31:0]          head_wdata,
  input  logic                 head_wdata_vld,
  input  logic [ROB_TAG_W-1:0] head_rob,
  input  logic [2:0]           head_funct3,
  output logic                 head_pop,
  output logic                 res_valid,
  output logic                 res_st,
  output logic                 res_exc,
  output logic [ROB_TAG_W-1:0] res_rob,
  output logic [31:0]          res_value,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  output logic [31:0]          pmem_wdata,
  output logic [3:0]           pmem_byte_enable,
  input  logic [31:0]          pmem_rdata,
  input  logic                 pmem_resp
);

  mem_state_e state_reg, state_next;
  res_bus_t   res_reg, res_next;
  logic pmem_read_reg, pmem_read_next, pmem_write_reg, pmem_write_next;
  logic [31:0] pmem_address_reg, pmem_address_next, pmem_wdata_reg, pmem_wdata_next;
  logic [3:0]  pmem_be_reg, pmem_be_next;
  logic [2:0]  ld_f3_reg, ld_f3_next;
  logic [1:0]  ld_off_reg, ld_off_next;
  logic [ROB_TAG_W-1:0] ld_rob_reg, ld_rob_next;
  logic flush_seen_reg, flush_seen_next;

  logic [1:0]  off;
  logic        ld_legal, st_legal, misal, st_req, st_push, st_exc_pop;
  logic        ld_req, ld_ok, ld_exc_pop, ld_pop, stb_pop;
  logic [3:0]  st_be;
  logic [31:0] st_data, ld_shift, ld_value;
  logic [29:0] stb_head_addr;
  logic [3:0]  stb_head_be;
  logic [31:0] stb_head_data;
  logic        stb_full, stb_empty, stb_match;

  assign off = head_addr[1:0];

  // Decode legality/alignment and shape the buffered store lanes
  always_comb begin
    ld_legal = (head_funct3 == F3_LB) || (head_funct3 == F3_LH) || (head_funct3 == F3_LW) ||
               (head_funct3 == F3_LBU) || (head_funct3 == F3_LHU);
    st_legal = (head_funct3 == F3_SB) || (head_funct3 == F3_SH) || (head_funct3 == F3_SW);
    misal    = is_misaligned(head_funct3, off);
    case (head_funct3[1:0])
      2'b00:   st_be = 4'b0001 << off;
      2'b01:   st_be = 4'b0011 << off;
      default: st_be = 4'b1111;
    endcase
    st_data = head_wdata << {off, 3'b000};
  end

  // Stores never enter while a load owns the head; bad ops leave without memory access
  assign st_req     = head_valid && head_is_st && head_addr_vld && head_wdata_vld && (state_reg != LD_WAIT);
  assign st_push    = st_req && st_legal && !misal && !stb_full;
  assign st_exc_pop = st_req && !(st_legal && !misal);
  assign ld_req     = head_valid && !head_is_st && head_addr_vld;
  assign ld_exc_pop = ld_req && !(ld_legal && !misal) && (state_reg != LD_WAIT);
  assign ld_ok      = ld_req && ld_legal && !misal && !stb_match;
  assign ld_pop     = (state_reg == LD_WAIT) && pmem_resp && !(flush || flush_seen_reg);
  assign stb_pop    = (state_reg == ST_WAIT) && pmem_resp;
  assign head_pop   = rst && (st_push || st_exc_pop || ld_exc_pop || ld_pop);

  ld_st_store_buffer #(.DEPTH(STB_DEPTH)) u_stb (
    .clk        (clk),
    .rst        (rst),
    .push       (st_push),
    .push_addr  (head_addr[31:2]),
    .push_be    (st_be),
    .push_data  (st_data),
    .pop        (stb_pop),
    .match_addr (head_addr[31:2]),
    .head_addr  (stb_head_addr),
    .head_be    (stb_head_be),
    .head_data  (stb_head_data),
    .full       (stb_full),
    .empty      (stb_empty),
    .match      (stb_match)
  );

  // Extract and extend the addressed byte/half of the returned word
  always_comb begin
    ld_shift = pmem_rdata >> {ld_off_reg, 3'b000};
    case (ld_f3_reg)
      F3_LB:   ld_value = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_LH:   ld_value = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_LBU:  ld_value = {24'b0, ld_shift[7:0]};
      F3_LHU:  ld_value = {16'b0, ld_shift[15:0]};
      default: ld_value = ld_shift;
    endcase
  end

  // Next state and memory request: full-buffer drain beats loads, loads beat idle drains
  always_comb begin
    state_next        = state_reg;
    pmem_read_next    = pmem_read_reg;
    pmem_write_next   = pmem_write_reg;
    pmem_address_next = pmem_address_reg;
    pmem_wdata_next   = pmem_wdata_reg;
    pmem_be_next      = pmem_be_reg;
    ld_f3_next        = ld_f3_reg;
    ld_off_next       = ld_off_reg;
    ld_rob_next       = ld_rob_reg;
    flush_seen_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (stb_full || (!ld_ok && !stb_empty)) begin
          state_next        = ST_WAIT;
          pmem_write_next   = 1'b1;
          pmem_address_next = {stb_head_addr, 2'b00};
          pmem_wdata_next   = stb_head_data;
          pmem_be_next      = stb_head_be;
        end else if (ld_ok) begin
          state_next        = LD_WAIT;
          pmem_read_next    = 1'b1;
          pmem_address_next = {head_addr[31:2], 2'b00};
          pmem_wdata_next   = '0;
          pmem_be_next      = '0;
          ld_f3_next        = head_funct3;
          ld_off_next       = off;
          ld_rob_next       = head_rob;
        end
      end
      LD_WAIT, ST_WAIT: begin
        if (state_reg == LD_WAIT) begin
          flush_seen_next = (flush_seen_reg || flush) && !pmem_resp;
        end
        if (pmem_resp) begin
          state_next        = IDLE;
          pmem_read_next    = 1'b0;
          pmem_write_next   = 1'b0;
          pmem_address_next = '0;
          pmem_wdata_next   = '0;
          pmem_be_next      = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result bus: at most one source per cycle since the head can only be one op
  always_comb begin
    res_next = '0;
    if (st_push || st_exc_pop) begin
      res_next.valid = 1'b1;
      res_next.st    = 1'b1;
      res_next.exc   = st_exc_pop;
      res_next.rob   = ROB_TAG_MAX'(head_rob);
    end else if (ld_exc_pop) begin
      res_next.valid = 1'b1;
      res_next.exc   = 1'b1;
      res_next.rob   = ROB_TAG_MAX'(head_rob);
    end else if (ld_pop) begin
      res_next.valid = 1'b1;
      res_next.rob   = ROB_TAG_MAX'(ld_rob_reg);
      res_next.value = ld_value;
    end
  end

  // All controller state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      res_reg          <= '0;
      pmem_read_reg    <= 1'b0;
      pmem_write_reg   <= 1'b0;
      pmem_address_reg <= '0;
      pmem_wdata_reg   <= '0;
      pmem_be_reg      <= '0;
      ld_f3_reg        <= '0;
      ld_off_reg       <= '0;
      ld_rob_reg       <= '0;
      flush_seen_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      res_reg          <= res_next;
      pmem_read_reg    <= pmem_read_next;
      pmem_write_reg   <= pmem_write_next;
      pmem_address_reg <= pmem_address_next;
      pmem_wdata_reg   <= pmem_wdata_next;
      pmem_be_reg      <= pmem_be_next;
      ld_f3_reg        <= ld_f3_next;
      ld_off_reg       <= ld_off_next;
      ld_rob_reg       <= ld_rob_next;
      flush_seen_reg   <= flush_seen_next;
    end
  end

  generate
    if (ROB_TAG_W < ROB_TAG_MAX) begin : g_rob_pad
      logic unused_rob_hi;
      assign unused_rob_hi = ^res_reg.rob[ROB_TAG_MAX-1:ROB_TAG_W];
    end
  endgenerate

  assign res_valid        = res_reg.valid;
  assign res_st           = res_reg.st;
  assign res_exc          = res_reg.exc;
  assign res_rob          = res_reg.rob[ROB_TAG_W-1:0];
  assign res_value        = res_reg.value;
  assign pmem_read        = pmem_read_reg;
  assign pmem_write       = pmem_write_reg;
  assign pmem_address     = pmem_address_reg;
  assign pmem_wdata       = pmem_wdata_reg;
  assign pmem_byte_enable = pmem_be_reg;

endmodule

// File: tb/tb_ld_st_mem_ctrl.sv
// Directed bench for ld_st_mem_ctrl; the bench acts as the memory.
module tb_ld_st_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        head_valid = 1'b0, head_is_st = 1'b0, head_addr_vld = 1'b0, head_wdata_vld = 1'b0;
  logic [31:0] head_addr = '0, head_wdata = '0;
  logic [4:0]  head_rob = '0;
  logic [2:0]  head_funct3 = '0;
  logic        head_pop, res_valid, res_st, res_exc;
  logic [4:0]  res_rob;
  logic [31:0] res_value;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address, pmem_wdata;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_rdata = '0;
  logic        pmem_resp = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int n_rd = 0, n_wr = 0, n_pop = 0, n_resv = 0;

  ld_st_mem_ctrl #(.ROB_TAG_W(5), .STB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .head_valid(head_valid), .head_is_st(head_is_st), .head_addr(head_addr),
    .head_addr_vld(head_addr_vld), .head_wdata(head_wdata), .head_wdata_vld(head_wdata_vld),
    .head_rob(head_rob), .head_funct3(head_funct3), .head_pop(head_pop),
    .res_valid(res_valid), .res_st(res_st), .res_exc(res_exc), .res_rob(res_rob),
    .res_value(res_value), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_byte_enable(pmem_byte_enable), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // Activity counters sampled mid-cycle
  always @(negedge clk) begin
    if (pmem_read)  n_rd   <= n_rd + 1;
    if (pmem_write) n_wr   <= n_wr + 1;
    if (head_pop)   n_pop  <= n_pop + 1;
    if (res_valid)  n_resv <= n_resv + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic st, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] f3, input logic [4:0] rob);
    head_valid = 1'b1; head_is_st = st; head_addr = addr; head_addr_vld = 1'b1;
    head_wdata = data; head_wdata_vld = 1'b1; head_funct3 = f3; head_rob = rob;
  endtask

  task automatic clear_head();
    head_valid = 1'b0; head_is_st = 1'b0; head_addr = '0; head_addr_vld = 1'b0;
    head_wdata = '0; head_wdata_vld = 1'b0; head_funct3 = '0; head_rob = '0;
  endtask

  // Present a store, expect an immediate pop and a store result next cycle
  task automatic push_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3,
                            input logic [4:0] rob, input logic exp_exc);
    set_head(1'b1, addr, data, f3, rob);
    #3;
    check("st_pop", 32'(head_pop), 32'd1);
    cyc();
    clear_head();
    check("st_res_valid", 32'(res_valid), 32'd1);
    check("st_res_st", 32'(res_st), 32'd1);
    check("st_res_exc", 32'(res_exc), 32'(exp_exc));
    check("st_res_rob", 32'(res_rob), 32'(rob));
    $display("[TB] store addr=%h data=%h f3=%0d rob=%0d", addr, data, f3, rob);
  endtask

  task automatic mem_wait(input string tag);
    for (int i = 0; i < 30 && !(pmem_read || pmem_write); i++) cyc();
    check(tag, 32'(pmem_read || pmem_write), 32'd1);
  endtask

  task automatic mem_respond(input logic [31:0] rd, output logic popped);
    pmem_rdata = rd;
    pmem_resp = 1'b1;
    #3;
    popped = head_pop;
    cyc();
    pmem_resp = 1'b0;
    pmem_rdata = '0;
  endtask

  // Issue a legal load from an empty buffer and check the extended value
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [4:0] rob, input logic [31:0] rd, input logic [31:0] exp);
    logic p;
    set_head(1'b0, addr, 32'd0, f3, rob);
    mem_wait({tag, "_req"});
    check({tag, "_addr"}, pmem_address, {addr[31:2], 2'b00});
    mem_respond(rd, p);
    clear_head();
    check({tag, "_pop"}, 32'(p), 32'd1);
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_st"}, 32'(res_st), 32'd0);
    check({tag, "_rob"}, 32'(res_rob), 32'(rob));
    check({tag, "_value"}, res_value, exp);
    $display("[TB] load %s addr=%h f3=%0d value=%h", tag, addr, f3, res_value);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p;
    int base_a, base_b;
    logic [31:0] mem_word;

    // Reset state
    repeat (2) cyc();
    check("rst_be", 32'(pmem_byte_enable), 32'd0);
    check("rst_rw", 32'({pmem_read, pmem_write}), 32'd0);
    check("rst_res", 32'({res_valid, res_st, res_exc}), 32'd0);
    check("rst_addr", pmem_address, 32'd0);
    rst = 1'b1;
    cyc();

    // sb 0x103 then drain
    push_store(32'h103, 32'hAB, 3'b000, 5'd3, 1'b0);
    mem_wait("sb_req");
    check("sb_write", 32'(pmem_write), 32'd1);
    check("sb_addr", pmem_address, 32'h100);
    check("sb_be", 32'(pmem_byte_enable), 32'b1000);
    check("sb_wdata", pmem_wdata, 32'hAB000000);
    mem_respond(32'd0, p);
    check("sb_drain_nopop", 32'(p), 32'd0);
    check("sb_drop", 32'(pmem_write), 32'd0);
    $display("[TB] drain sb done");

    // sh 0x102 lanes
    push_store(32'h102, 32'h1234, 3'b001, 5'd5, 1'b0);
    mem_wait("sh_req");
    check("sh_be", 32'(pmem_byte_enable), 32'b1100);
    check("sh_wdata", pmem_wdata, 32'h12340000);
    mem_respond(32'd0, p);

    // lb / lbu extension
    do_load("lb", 32'h201, 3'b000, 5'd7, 32'h0000F000, 32'hFFFFFFF0);
    cyc();
    check("idle_value", res_value, 32'd0);
    do_load("lbu", 32'h201, 3'b100, 5'd8, 32'h0000F000, 32'h000000F0);
    do_load("lh", 32'h202, 3'b001, 5'd9, 32'h8001_0000, 32'hFFFF8001);

    // sw then lw to the same word: store must drain first
    push_store(32'h300, 32'hDEADBEEF, 3'b010, 5'd1, 1'b0);
    set_head(1'b0, 32'h300, 32'd0, 3'b010, 5'd2);
    base_a = n_rd;
    mem_wait("raw_first");
    check("raw_first_is_write", 32'({pmem_read, pmem_write}), 32'b01);
    mem_word = pmem_wdata;
    mem_respond(32'd0, p);
    check("raw_no_early_read", 32'(n_rd - base_a), 32'd0);
    mem_wait("raw_load");
    check("raw_load_is_read", 32'(pmem_read), 32'd1);
    check("raw_load_addr", pmem_address, 32'h300);
    mem_respond(mem_word, p);
    clear_head();
    check("raw_pop", 32'(p), 32'd1);
    check("raw_value", res_value, 32'hDEADBEEF);
    check("raw_rob", 32'(res_rob), 32'd2);
    $display("[TB] load raw value=%h", res_value);

    // Fill buffer with drain stuck; fifth store waits for first drain
    for (int k = 0; k < 4; k++) push_store(32'h400 + 32'(4 * k), 32'(k), 3'b010, 5'(10 + k), 1'b0);
    set_head(1'b1, 32'h410, 32'd4, 3'b010, 5'd14);
    base_a = n_pop;
    repeat (4) cyc();
    check("full_no_pop", 32'(n_pop - base_a), 32'd0);
    check("full_drain_addr", pmem_address, 32'h400);
    mem_respond(32'd0, p);
    check("full_resp_nopop", 32'(p), 32'd0);
    #3;
    check("full_fifth_pop", 32'(head_pop), 32'd1);
    cyc();
    clear_head();
    check("full_fifth_res", 32'(res_valid), 32'd1);
    for (int k = 1; k < 5; k++) begin
      mem_wait("full_drain");
      check("full_drain_order", pmem_address, 32'h400 + 32'(4 * k));
      mem_respond(32'd0, p);
      $display("[TB] drain %0d addr done", k);
    end

    // Misaligned lw: exception, no read ever
    base_a = n_rd;
    set_head(1'b0, 32'h302, 32'd0, 3'b010, 5'd9);
    #3;
    check("mis_pop", 32'(head_pop), 32'd1);
    cyc();
    clear_head();
    check("mis_exc", 32'({res_valid, res_st, res_exc}), 32'b101);
    check("mis_value", res_value, 32'd0);
    check("mis_rob", 32'(res_rob), 32'd9);
    repeat (3) cyc();
    check("mis_no_read", 32'(n_rd - base_a), 32'd0);
    $display("[TB] misaligned lw checked");

    // Illegal store funct3: exception and nothing buffered
    base_a = n_wr;
    push_store(32'h700, 32'h55, 3'b011, 5'd11, 1'b1);
    repeat (3) cyc();
    check("ill_no_write", 32'(n_wr - base_a), 32'd0);

    // Flush while waiting on a load
    set_head(1'b0, 32'h500, 32'd0, 3'b010, 5'd4);
    mem_wait("flush_req");
    base_a = n_pop;
    base_b = n_resv;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    mem_respond(32'h12345678, p);
    clear_head();
    repeat (2) cyc();
    check("flush_no_pop", 32'(n_pop - base_a), 32'd0);
    check("flush_no_res", 32'(n_resv - base_b), 32'd0);
    $display("[TB] flushed load checked");

    // Reset while a drain is outstanding
    push_store(32'h600, 32'h77, 3'b010, 5'd12, 1'b0);
    mem_wait("rst_st_req");
    rst = 1'b0;
    #1;
    check("rst_mid_rw", 32'({pmem_read, pmem_write}), 32'd0);
    check("rst_mid_be", 32'(pmem_byte_enable), 32'd0);
    check("rst_mid_addr", pmem_address, 32'd0);
    check("rst_mid_res", 32'({res_valid, head_pop}), 32'd0);
    cyc();
    cyc();
    rst = 1'b1;
    base_a = n_wr;
    base_b = n_pop;
    repeat (4) cyc();
    check("rst_buf_empty", 32'(n_wr - base_a), 32'd0);
    check("rst_no_pop", 32'(n_pop - base_b), 32'd0);
    $display("[TB] reset mid-drain checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
